// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and width helper for the scan mux
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Minimum bits needed to index n items; n >= 2 always gives at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - combinational N-to-1 channel selector with range flag
module mux_nto1
  import mux_pkg::*;
#(
  parameter int N_CH  = 32,
  parameter int W     = 1,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] D,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      data,
  output logic              out_of_range
);

  // Decode against real channel numbers only, so selects past N_CH-1 yield zero.
  always_comb begin
    data         = '0;
    out_of_range = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        data         = D[k*W +: W];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - registered N-channel mux with manual/round-robin select and valid/ready output
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int N_CH  = 32,
  parameter int W     = 1,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N_CH*W-1:0] D,
  input  logic [SEL_W-1:0]  s,
  output logic [W-1:0]      Y,
  output logic [SEL_W-1:0]  y_ch,
  output logic              y_last,
  output logic              y_err,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     sel_data;
  logic             sel_oor;
  logic             load;

  assign sel  = (mode == MODE_SCAN) ? scan_ptr : s;
  assign load = en && (!y_valid || y_ready);

  mux_nto1 #(
    .N_CH (N_CH),
    .W    (W),
    .SEL_W(SEL_W)
  ) u_sel (
    .D           (D),
    .sel         (sel),
    .data        (sel_data),
    .out_of_range(sel_oor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y       <= '0;
      y_ch    <= '0;
      y_last  <= 1'b0;
      y_err   <= 1'b0;
      y_valid <= 1'b0;
    end else if (load) begin
      Y       <= sel_data;
      y_ch    <= sel;
      y_last  <= (mode == MODE_SCAN) && (sel == LAST_CH);
      y_err   <= (mode == MODE_MANUAL) && sel_oor;
      y_valid <= 1'b1;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Pointer parks at 0 in manual mode so the first scan word is always channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
    end else if (mode == MODE_MANUAL) begin
      scan_ptr <= '0;
    end else if (load) begin
      scan_ptr <= (scan_ptr == LAST_CH) ? '0 : scan_ptr + 1'b1;
    end
  end

endmodule
